// File: rtl/alu_exec.sv
// ============================================================================
//  Module   : alu_exec
//  Brief    : Registered RV32I execute-stage ALU with branch-condition flag.
//             Optional macro ALU_FLAGS_EN adds registered zero/negative/overflow.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_op,
    input  logic [5:0]        ALU_Control,
    input  logic [DATA_W-1:0] operand_A,
    input  logic [DATA_W-1:0] operand_B,
    output logic [DATA_W-1:0] ALU_result,
`ifdef ALU_FLAGS_EN
    output logic              zero,
    output logic              negative,
    output logic              overflow,
`endif
    output logic              branch
);

    localparam logic [5:0] c_add    = 6'b000_000;
    localparam logic [5:0] c_sub    = 6'b001_000;
    localparam logic [5:0] c_sll    = 6'b000_001;
    localparam logic [5:0] c_slt    = 6'b000_010;
    localparam logic [5:0] c_sltu   = 6'b000_011;
    localparam logic [5:0] c_xor    = 6'b000_100;
    localparam logic [5:0] c_srl    = 6'b000_101;
    localparam logic [5:0] c_sra    = 6'b001_101;
    localparam logic [5:0] c_or     = 6'b000_110;
    localparam logic [5:0] c_and    = 6'b000_111;
    localparam logic [5:0] c_pass_b = 6'b011_000;
    localparam logic [5:0] c_pass_a = 6'b111_111;
    localparam logic [2:0] c_class_branch = 3'b010;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [4:0]        w_shamt;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_eq;
    logic              w_cond;

    logic [DATA_W-1:0] result_d, result_q;
    logic              branch_d, branch_q;

    always_comb begin
        w_sum   = operand_A + operand_B;
        w_diff  = operand_A - operand_B;
        w_shamt = operand_B[4:0];
        w_lt_s  = $signed(operand_A) < $signed(operand_B);
        w_lt_u  = operand_A < operand_B;
        w_eq    = operand_A == operand_B;
        w_cond   = 1'b0;
        result_d = '0;
        branch_d = 1'b0;

        if (ALU_Control[5:3] == c_class_branch) begin
            case (ALU_Control[2:0])
                3'b000:  w_cond = w_eq;
                3'b001:  w_cond = !w_eq;
                3'b100:  w_cond = w_lt_s;
                3'b101:  w_cond = !w_lt_s;
                3'b110:  w_cond = w_lt_u;
                3'b111:  w_cond = !w_lt_u;
                default: w_cond = 1'b0;
            endcase
            branch_d = w_cond;
            // Branch unit may consume the raw difference instead of the flag
            result_d = branch_op ? w_diff : {{(DATA_W-1){1'b0}}, w_cond};
        end else begin
            case (ALU_Control)
                c_add:    result_d = w_sum;
                c_sub:    result_d = w_diff;
                c_sll:    result_d = operand_A << w_shamt;
                c_slt:    result_d = {{(DATA_W-1){1'b0}}, w_lt_s};
                c_sltu:   result_d = {{(DATA_W-1){1'b0}}, w_lt_u};
                c_xor:    result_d = operand_A ^ operand_B;
                c_srl:    result_d = operand_A >> w_shamt;
                c_sra:    result_d = $unsigned($signed(operand_A) >>> w_shamt);
                c_or:     result_d = operand_A | operand_B;
                c_and:    result_d = operand_A & operand_B;
                c_pass_b: result_d = operand_B;
                c_pass_a: result_d = operand_A;
                default:  result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign ALU_result = result_q;
    assign branch     = branch_q;

`ifdef ALU_FLAGS_EN
    logic zero_d, zero_q;
    logic negative_d, negative_q;
    logic overflow_d, overflow_q;

    always_comb begin
        zero_d     = (result_d == '0);
        negative_d = result_d[DATA_W-1];
        overflow_d = 1'b0;
        // Signed overflow: operand signs permit it and the result sign flips
        if (ALU_Control == c_add) begin
            overflow_d = (operand_A[DATA_W-1] == operand_B[DATA_W-1]) &&
                         (w_sum[DATA_W-1] != operand_A[DATA_W-1]);
        end else if (ALU_Control == c_sub) begin
            overflow_d = (operand_A[DATA_W-1] != operand_B[DATA_W-1]) &&
                         (w_diff[DATA_W-1] != operand_A[DATA_W-1]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  Module   : tb_alu_exec
//  Brief    : Self-checking bench for alu_exec: directed literals plus random
//             stimulus against a behavioural model. Honours ALU_FLAGS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_op = 1'b0;
    logic [5:0]  ALU_Control = 6'd0;
    logic [31:0] operand_A = 32'd0;
    logic [31:0] operand_B = 32'd0;
    logic [31:0] ALU_result;
    logic        branch;
`ifdef ALU_FLAGS_EN
    logic        zero, negative, overflow;
`endif

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    alu_exec #(.DATA_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .branch_op   (branch_op),
        .ALU_Control (ALU_Control),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .ALU_result  (ALU_result),
`ifdef ALU_FLAGS_EN
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
`endif
        .branch      (branch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model in terms of the instruction semantics (octal = {class,op})
    function automatic void model(input logic [5:0] ctrl, input logic bop,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br,
                                  output logic z, output logic n, output logic v);
        longint sa, sb, s;
        int     sh;
        logic   c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        r = 32'd0; br = 1'b0; v = 1'b0; c = 1'b0;
        if (ctrl[5:3] == 3'o2) begin
            case (ctrl[2:0])
                3'o0: c = (a == b);
                3'o1: c = (a != b);
                3'o4: c = (sa < sb);
                3'o5: c = (sa >= sb);
                3'o6: c = (a < b);
                3'o7: c = (a >= b);
                default: c = 1'b0;
            endcase
            br = c;
            r  = bop ? 32'(sa - sb) : {31'd0, c};
        end else begin
            case (ctrl)
                6'o00: begin s = sa + sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'o10: begin s = sa - sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'o01: r = 32'(64'(a) * (64'd1 << sh));
                6'o02: r = {31'd0, sa < sb};
                6'o03: r = {31'd0, a < b};
                6'o04: r = a ^ b;
                6'o05: r = 32'(64'(a) / (64'd1 << sh));
                6'o15: r = 32'((sa < 0) ? -((-sa + (64'sd1 << sh) - 1) / (64'sd1 << sh))
                                        : sa / (64'sd1 << sh));
                6'o06: r = a | b;
                6'o07: r = a & b;
                6'o30: r = b;
                6'o77: r = a;
                default: r = 32'd0;
            endcase
        end
        z = (r == 32'd0);
        n = r[31];
    endfunction

    logic [31:0] exp_r;
    logic        exp_br, exp_z, exp_n, exp_v;

    always @(posedge clock or posedge reset) begin
        logic [31:0] r;
        logic b, z, n, v;
        if (reset) begin
            exp_r <= 32'd0; exp_br <= 1'b0; exp_z <= 1'b0; exp_n <= 1'b0; exp_v <= 1'b0;
        end else begin
            model(ALU_Control, branch_op, operand_A, operand_B, r, b, z, n, v);
            exp_r <= r; exp_br <= b; exp_z <= z; exp_n <= n; exp_v <= v;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("model_result", ALU_result, exp_r);
            chk("model_branch", {31'd0, branch}, {31'd0, exp_br});
`ifdef ALU_FLAGS_EN
            chk("model_zero", {31'd0, zero}, {31'd0, exp_z});
            chk("model_negative", {31'd0, negative}, {31'd0, exp_n});
            chk("model_overflow", {31'd0, overflow}, {31'd0, exp_v});
`endif
        end
    end

    task automatic directed(input string name, input logic [5:0] ctrl, input logic bop,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic eb);
        ALU_Control = ctrl; branch_op = bop; operand_A = a; operand_B = b;
        @(posedge clock); #1;
        chk({name, "_result"}, ALU_result, er);
        chk({name, "_branch"}, {31'd0, branch}, {31'd0, eb});
    endtask

    logic [5:0] codes [0:18] = '{6'o00, 6'o10, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o15,
                                 6'o06, 6'o07, 6'o30, 6'o77, 6'o20, 6'o21, 6'o22, 6'o24,
                                 6'o25, 6'o26, 6'o27};
    logic [31:0] corners [0:5] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                   32'h1, 32'h1F};

    function automatic logic [31:0] rand_op();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1;
        chk("reset_result", ALU_result, 32'd0);
        chk("reset_branch", {31'd0, branch}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        directed("add",        6'o00, 1'b0, 32'd4, 32'd5, 32'd9, 1'b0);
        directed("slt",        6'o02, 1'b0, 32'd4, 32'd5, 32'd1, 1'b0);
        directed("slt_neg1",   6'o02, 1'b0, 32'd4, 32'hFFFF_FFFF, 32'd0, 1'b0);
        directed("sll_31",     6'o01, 1'b0, 32'd4, 32'hFFFF_FFFF, 32'd0, 1'b0);
        directed("pass_a",     6'o77, 1'b0, 32'd4, 32'h1234_5678, 32'd4, 1'b0);
        directed("pass_b",     6'o30, 1'b1, 32'd4, 32'h1234_5000, 32'h1234_5000, 1'b0);
        directed("slt_m5",     6'o02, 1'b0, 32'd4, 32'hFFFF_FFFB, 32'd0, 1'b0);
        directed("sltu_m5",    6'o03, 1'b0, 32'd4, 32'hFFFF_FFFB, 32'd1, 1'b0);
        directed("bltu",       6'o26, 1'b0, 32'd4, 32'd9, 32'd1, 1'b1);
        directed("beq_diff",   6'o20, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        directed("bne_diff",   6'o21, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        directed("blt_diff",   6'o24, 1'b1, 32'd3, 32'd7, 32'hFFFF_FFFC, 1'b1);
        directed("reserved",   6'o22, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0);
        directed("sra",        6'o15, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        directed("srl",        6'o05, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
        directed("sub_wrap",   6'o10, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        directed("slt_edge",   6'o02, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        directed("sltu_edge",  6'o03, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0);
        directed("add_wrap",   6'o00, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
        directed("undefined",  6'o11, 1'b1, 32'd5, 32'd6, 32'd0, 1'b0);

        // Asynchronous reset mid-operation
        directed("add_pre_rst", 6'o00, 1'b0, 32'd4, 32'd5, 32'd9, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_result", ALU_result, 32'd0);
        chk("async_rst_branch", {31'd0, branch}, 32'd0);
        ALU_Control = 6'o04; operand_A = 32'hF0; operand_B = 32'h0F;
        @(posedge clock); #1;
        chk("rst_held_result", ALU_result, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_result", ALU_result, 32'hFF);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ALU_Control = 6'($urandom);
            else ALU_Control = codes[$urandom_range(0, 18)];
            branch_op = 1'($urandom);
            operand_A = rand_op();
            operand_B = (i % 2 == 0) ? operand_A : rand_op();
            if (i % 7 == 0) operand_B = rand_op();
            @(posedge clock); #1;
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
